// File: rtl/auction_pkg.sv
// Shared definitions for the Vickrey auction controller: FSM state encoding
// and bidder-count derivation.
package auction_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int nb_of(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/vickrey_scan_step.sv
// One comparison step of the second-price search. Strict compares make the
// lowest index win a tie, while an equal later bid still raises the price.
module vickrey_scan_step #(
  parameter int N = 3,
  parameter int W = 3
) (
  input  logic [W-1:0] b,
  input  logic [N-1:0] idx,
  input  logic [W-1:0] best,
  input  logic [W-1:0] second,
  input  logic [N-1:0] win,
  output logic [W-1:0] best_n,
  output logic [W-1:0] second_n,
  output logic [N-1:0] win_n
);

  always_comb begin
    best_n   = best;
    second_n = second;
    win_n    = win;
    if (b > best) begin
      second_n = best;
      best_n   = b;
      win_n    = idx;
    end else if (b > second) begin
      second_n = b;
    end
  end

endmodule

// File: rtl/vickrey_auction_ctrl.sv
// Serial second-price auction: loads NB bids over valid/ready, scans them one
// per cycle, then holds winner/max_bid/price until the consumer accepts.
module vickrey_auction_ctrl
  import auction_pkg::*;
#(
  parameter int N = 3,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         bid_valid,
  input  logic [W-1:0] bid_data,
  output logic         bid_ready,
  output logic         busy,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] winner,
  output logic [W-1:0] max_bid,
  output logic [W-1:0] price
);

  localparam int NB = nb_of(N);
  localparam logic [N:0] LAST_IDX = (N+1)'(NB - 1);

  state_t       state_q, state_d;
  logic [N:0]   idx_q, idx_d;
  logic [W-1:0] best_q, best_d;
  logic [W-1:0] second_q, second_d;
  logic [N-1:0] win_q, win_d;
  logic [W-1:0] bid_file_q [NB];
  logic [W-1:0] bid_file_d [NB];

  logic [W-1:0] scan_bid;
  logic [W-1:0] step_best, step_second;
  logic [N-1:0] step_win;

  assign scan_bid = bid_file_q[idx_q[N-1:0]];

  vickrey_scan_step #(.N(N), .W(W)) u_step (
    .b        (scan_bid),
    .idx      (idx_q[N-1:0]),
    .best     (best_q),
    .second   (second_q),
    .win      (win_q),
    .best_n   (step_best),
    .second_n (step_second),
    .win_n    (step_win)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    best_d     = best_q;
    second_d   = second_q;
    win_d      = win_q;
    bid_file_d = bid_file_q;

    // abort outranks every other event, including a bid arriving this cycle
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = LOAD;
            idx_d   = '0;
          end
        end
        LOAD: begin
          if (bid_valid) begin
            bid_file_d[idx_q[N-1:0]] = bid_data;
            if (idx_q == LAST_IDX) begin
              state_d  = SCAN;
              idx_d    = '0;
              best_d   = '0;
              second_d = '0;
              win_d    = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        SCAN: begin
          best_d   = step_best;
          second_d = step_second;
          win_d    = step_win;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      best_q   <= '0;
      second_q <= '0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      best_q   <= best_d;
      second_q <= second_d;
      win_q    <= win_d;
    end
  end

  // The bid file is pure storage and is fully rewritten before every scan.
  always_ff @(posedge clk) begin
    bid_file_q <= bid_file_d;
  end

  assign bid_ready = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DONE);
  assign winner    = win_q;
  assign max_bid   = best_q;
  assign price     = second_q;

endmodule

// File: tb/tb_vickrey_auction_ctrl.sv
// Scoreboard bench for vickrey_auction_ctrl: directed auctions push expected
// results; a negedge monitor pops and compares whenever a result is consumed.
module tb_vickrey_auction_ctrl;

   localparam int N  = 3;
   localparam int W  = 3;
   localparam int NB = 8;

   typedef struct packed {
      logic [N-1:0] winner;
      logic [W-1:0] maxBid;
      logic [W-1:0] price;
   } result_t;

   typedef logic [W-1:0] bidVec_t [NB];

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         abort;
   logic         bid_valid;
   logic [W-1:0] bid_data;
   logic         bid_ready;
   logic         busy;
   logic         res_valid;
   logic         res_ready;
   logic [N-1:0] winner;
   logic [W-1:0] max_bid;
   logic [W-1:0] price;

   int      testsRun    = 0;
   int      testsFailed = 0;
   result_t expQ[$];
   int      lat;

   vickrey_auction_ctrl #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .bid_valid (bid_valid),
      .bid_data  (bid_data),
      .bid_ready (bid_ready),
      .busy      (busy),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .winner    (winner),
      .max_bid   (max_bid),
      .price     (price)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Single comparison point shared by the monitor and the directed checks
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Start an auction and stream the first 'count' bids, optionally with random bid_valid gaps
   task automatic applyStimulus(input bidVec_t bids, input bit gaps, input int count);
      @(posedge clk) #1 start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      checkOutput("bidReadyAfterStart", {31'd0, bid_ready}, 32'd1);
      for (int i = 0; i < count; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
               bid_valid = 1'b0;
               bid_data  = W'($urandom);
               @(posedge clk) #1;
            end
         end
         bid_valid = 1'b1;
         bid_data  = bids[i];
         @(posedge clk) #1;
      end
      bid_valid = 1'b0;
   endtask

   // Count edges from the last accepted bid until res_valid, optionally poking start while busy
   task automatic waitResult(input bit pokeStart, output int edges);
      edges = 0;
      while (!res_valid && edges < 64) begin
         start = pokeStart && (edges < 3);
         @(posedge clk) #1;
         edges++;
      end
      start = 1'b0;
   endtask

   // Compare each consumed result against the oldest expectation
   always @(negedge clk) begin : monitor
      result_t e;
      if (!rst && res_valid && res_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedResult", 32'd1, 32'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("winner", {29'd0, winner}, {29'd0, e.winner});
            checkOutput("maxBid", {29'd0, max_bid}, {29'd0, e.maxBid});
            checkOutput("price", {29'd0, price}, {29'd0, e.price});
         end
      end
   end

   // Hard stop in case the stimulus itself gets stuck
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed auction sequence
   initial begin
      bidVec_t b;
      rst       = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      bid_valid = 1'b0;
      bid_data  = '0;
      res_ready = 1'b1;
      #12;
      checkOutput("resetBidReady", {31'd0, bid_ready}, 32'd0);
      checkOutput("resetBusy", {31'd0, busy}, 32'd0);
      checkOutput("resetResValid", {31'd0, res_valid}, 32'd0);
      checkOutput("resetWinner", {29'd0, winner}, 32'd0);
      checkOutput("resetMaxBid", {29'd0, max_bid}, 32'd0);
      checkOutput("resetPrice", {29'd0, price}, 32'd0);
      @(negedge clk) rst = 1'b0;

      $display("[TB] back-to-back bids 6,0,1,4,3,7,5,2");
      b = '{3'd6, 3'd0, 3'd1, 3'd4, 3'd3, 3'd7, 3'd5, 3'd2};
      expQ.push_back('{winner: 3'd5, maxBid: 3'd7, price: 3'd6});
      applyStimulus(b, 1'b0, NB);
      checkOutput("bidReadyAfterLast", {31'd0, bid_ready}, 32'd0);
      waitResult(1'b0, lat);
      checkOutput("latency", lat, NB);
      @(posedge clk) #1;
      checkOutput("idleAfterConsume", {31'd0, busy}, 32'd0);

      $display("[TB] all bids 3, start poked during scan");
      b = '{default: 3'd3};
      expQ.push_back('{winner: 3'd0, maxBid: 3'd3, price: 3'd3});
      applyStimulus(b, 1'b0, NB);
      waitResult(1'b1, lat);
      checkOutput("latencyStartIgnored", lat, NB);
      @(posedge clk) #1;
      checkOutput("idleAfterAllThree", {31'd0, busy}, 32'd0);

      $display("[TB] all bids 0");
      b = '{default: 3'd0};
      expQ.push_back('{winner: 3'd0, maxBid: 3'd0, price: 3'd0});
      applyStimulus(b, 1'b0, NB);
      waitResult(1'b0, lat);
      @(posedge clk) #1;

      $display("[TB] bids 7,7,0.. with bid_valid gaps");
      b = '{3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
      expQ.push_back('{winner: 3'd0, maxBid: 3'd7, price: 3'd7});
      applyStimulus(b, 1'b1, NB);
      checkOutput("gapsAllAccepted", {31'd0, bid_ready}, 32'd0);
      waitResult(1'b0, lat);
      checkOutput("latencyGaps", lat, NB);
      @(posedge clk) #1;

      $display("[TB] result held with res_ready low");
      res_ready = 1'b0;
      b = '{3'd6, 3'd0, 3'd1, 3'd4, 3'd3, 3'd7, 3'd5, 3'd2};
      expQ.push_back('{winner: 3'd5, maxBid: 3'd7, price: 3'd6});
      applyStimulus(b, 1'b0, NB);
      waitResult(1'b0, lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("holdResValid", {31'd0, res_valid}, 32'd1);
         checkOutput("holdWinner", {29'd0, winner}, 32'd5);
         checkOutput("holdMaxBid", {29'd0, max_bid}, 32'd7);
         checkOutput("holdPrice", {29'd0, price}, 32'd6);
      end
      @(posedge clk) #1 res_ready = 1'b1;
      @(posedge clk) #1;
      checkOutput("idleAfterLateReady", {31'd0, busy}, 32'd0);

      $display("[TB] abort after four bids, then a fresh auction");
      b = '{3'd5, 3'd6, 3'd7, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0};
      applyStimulus(b, 1'b0, 4);
      abort     = 1'b1;
      bid_valid = 1'b1;
      bid_data  = 3'd7;
      @(posedge clk) #1;
      abort     = 1'b0;
      bid_valid = 1'b0;
      checkOutput("abortBidReady", {31'd0, bid_ready}, 32'd0);
      checkOutput("abortBusy", {31'd0, busy}, 32'd0);
      checkOutput("abortResValid", {31'd0, res_valid}, 32'd0);
      b = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
      expQ.push_back('{winner: 3'd6, maxBid: 3'd7, price: 3'd6});
      applyStimulus(b, 1'b0, NB);
      waitResult(1'b0, lat);
      checkOutput("latencyAfterAbort", lat, NB);
      @(posedge clk) #1;

      $display("[TB] async reset mid-scan");
      b = '{3'd6, 3'd0, 3'd1, 3'd4, 3'd3, 3'd7, 3'd5, 3'd2};
      applyStimulus(b, 1'b0, NB);
      repeat (6) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checkOutput("midRstBidReady", {31'd0, bid_ready}, 32'd0);
      checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
      checkOutput("midRstResValid", {31'd0, res_valid}, 32'd0);
      checkOutput("midRstWinner", {29'd0, winner}, 32'd0);
      checkOutput("midRstMaxBid", {29'd0, max_bid}, 32'd0);
      checkOutput("midRstPrice", {29'd0, price}, 32'd0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk) #1;
      checkOutput("idleAfterRst", {31'd0, busy}, 32'd0);

      checkOutput("scoreboardDrained", expQ.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/vickrey_auction_ctrl.md
# vickrey_auction_ctrl

Sequential second-price (Vickrey) auction controller for 2**N bidders of W-bit bids. Collects bids one per cycle over a valid/ready stream into an internal bid register file, scans them to find the highest bidder and the second-highest bid, then holds the result under a valid/ready handshake. It is the clocked front end that lets bids arrive serially from an input port instead of as one flattened bus.

## Interface
- N, 3, log2 of bidder count (NB = 2**N bidders)
- W, 3, bid width in bits (unsigned)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a new auction (sampled only in IDLE)
- abort  input  1  cancel the current auction, any state
- bid_valid  input  1  bid_data valid
- bid_data  input  W  bid of bidder index = number of bids accepted so far
- bid_ready  output  1  controller accepts a bid this cycle
- busy  output  1  state != IDLE
- res_valid  output  1  result valid
- res_ready  input  1  consumer takes result
- winner  output  N  index of the highest bid
- max_bid  output  W  highest bid
- price  output  W  second-highest bid (the price paid)

## Operation
- States: IDLE, LOAD, SCAN, DONE; encoded in 2 bits.
- IDLE: bid_ready=0, res_valid=0. start=1 -> LOAD, idx<=0.
- LOAD: bid_ready=1. On bid_valid&bid_ready: bids[idx]<=bid_data, idx<=idx+1. Accepting idx=NB-1 -> SCAN, idx<=0, best<=0, second<=0, win<=0. idx is N+1 bits internally, with no wrap before the transition.
- SCAN: one entry per cycle, b=bids[idx]:
  - if b > best: second<=best, best<=b, win<=idx
  - else if b > second: second<=b
  - after idx=NB-1 -> DONE.
- Ties: strict compare, so lowest index wins. An equal later bid sets price equal to max_bid. All-zero bids give winner=0, price=0.
- DONE: res_valid=1; winner/max_bid/price stable. res_valid&res_ready -> IDLE.
- abort=1 in any state -> IDLE next edge, res_valid drops, the partial bid file is discarded. abort has priority over start, bid acceptance and res_ready.
- start outside IDLE is ignored.
- Reset values: state=IDLE, bid_ready=0, busy=0, res_valid=0, winner=0, max_bid=0, price=0, idx=0. The bid file is not reset.

## Timing
- All outputs are registered or decoded from the state register; no combinational input-to-output path except none.
- start at edge t -> bid_ready=1 from cycle t+1.
- Last bid accepted at edge t -> SCAN occupies cycles t+1..t+NB -> res_valid=1 from cycle t+NB+1.
- Min auction duration from start: 1 + NB + NB + 1 cycles, plus the result handshake.
- res_ready may be high before res_valid; the result is consumed on the first cycle both are high. With res_ready held high, IDLE is reached the cycle after res_valid rises.
- bid_valid gaps stall LOAD with no loss. bid_valid outside LOAD is ignored and not stored.
- Reset mid-operation: immediate return to reset values, independent of clk.

## Structure
- Shared package/header auction_pkg: state encodings (IDLE=0, LOAD=1, SCAN=2, DONE=3) and NB derivation.
- One natural sub-module, vickrey_scan_step: combinational update of {best, second, win} from {b, idx}. It is instantiated once in the controller and reusable by a future parallel tree.
- Bid file: NB x W register array, written in LOAD, read by idx in SCAN.

## Test plan
- Bids 6,0,1,4,3,7,5,2 streamed back-to-back -> winner=5, max_bid=7, price=6; res_valid exactly NB+1 cycles after the last bid.
- All bids =3 -> winner=0, max_bid=3, price=3. All bids =0 -> winner=0, price=0.
- Bids 7,7,0,... (rest 0) with random bid_valid gaps -> winner=0, price=7; no bid dropped or duplicated.
- res_ready low for 5 cycles in DONE -> outputs stable and res_valid high throughout; IDLE one cycle after res_ready rises.
- abort after 4 accepted bids -> IDLE next cycle with bid_ready=0. A new start plus bids 1..7,0 -> winner=6, price=6.
- Async rst asserted mid-SCAN between edges -> all outputs go to reset values immediately. start ignored while busy.
